mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port MemGen-style SRAM macro (chip_en/wr_en/rd_en/addr/wr_data/rd_data) between two requesters.
- Each requester issues commands over a valid/ready channel and receives read responses on a one-cycle strobe.
- Arbitration is round-robin and fully pipelined: up to one access per cycle.
- Sits between the requesting logic and the memory wrapper (submodule-level) instance.

Parameters:
AW, 10, memory address width
DW, 16, memory data width
RD_LAT, 1, macro read latency in cycles from the rd_en sampling edge to valid rd_data (legal 1..4)

Ports:
clock  in  1  single clock; all logic rising-edge
reset_n  in  1  synchronous, active-low reset
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 command accepted this cycle
req0_wr  in  1  1 = write, 0 = read
req0_addr  in  AW  requester 0 address
req0_wdata  in  DW  requester 0 write data
rsp0_valid  out  1  one-cycle strobe: read data for requester 0
rsp0_rdata  out  DW  read data for requester 0
req1_valid, req1_ready, req1_wr, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata  as above, for requester 1
mem_chip_en  out  1  to macro chip_en
mem_wr_en  out  1  to macro wr_en
mem_rd_en  out  1  to macro rd_en
mem_addr  out  AW  to macro addr
mem_wr_data  out  DW  to macro wr_data
mem_rd_data  in  DW  from macro rd_data

Behaviour:
- Reset: sampled at the rising clock edge while reset_n=0.
  - All mem_* outputs, rsp*_valid and rsp*_rdata go to 0.
  - req*_ready is held 0 combinationally while reset_n=0.
  - Round-robin pointer resets to favour requester 0.
  - In-flight read tracking is cleared; a read pending at reset never produces a response.
- Arbitration (combinational, per cycle):
  - Only req0_valid=1: grant 0.
  - Only req1_valid=1: grant 1.
  - Both valid: grant the requester named by the pointer.
  - req*_ready = grant to that requester; at most one ready per cycle; no ready when neither is valid.
- Pointer: on every accepted transfer (valid & ready), the pointer moves to the non-granted requester. With no acceptance, it holds.
- Requester rules: once valid is raised, valid and payload stay stable until ready. Never raising valid never blocks the other requester.
- Command issue (registered):
  - On the acceptance edge, mem_addr and mem_wr_data load from the winner.
  - mem_wr_en = winner's wr bit; mem_rd_en = its inverse; mem_chip_en = 1.
  - Controls are high for exactly one cycle per accepted command; back-to-back acceptances give back-to-back commands.
  - In idle cycles, mem_chip_en/wr_en/rd_en = 0; mem_addr and mem_wr_data hold their last value.
- Read return:
  - A tracking shift register of depth RD_LAT+1 carries {is_read, requester_id} per issued command.
  - At the stage where macro data is valid, mem_rd_data is registered into rspN_rdata and rspN_valid pulses for one cycle.
  - rspN_valid appears in the cycle beginning RD_LAT+1 edges after the acceptance edge (RD_LAT=1: 2 edges).
  - rsp*_rdata holds until the next response to that requester.
  - Writes produce no response.
  - Responses are never back-pressured.
  - Per-requester responses return in issue order.
- Hazards:
  - Same-address write then read (any requester, any spacing) returns the new data, because macro accesses are serialised in grant order.
  - No bypass logic is needed.
- Reset mid-operation: outstanding reads are dropped as above. After reset_n returns to 1, arbitration resumes next cycle with the pointer at requester 0.

Test Plan:
- Reset with both valid, then release → cycle 1 grants req0 (addr 0x005), cycle 2 req1 (addr 0x3FF), cycle 3 req0; mem_chip_en is high for 3 consecutive cycles.
- req0 writes 0xA5A5 @0x010, then reads @0x010 → rsp0_valid pulses once, 2 edges after the read acceptance (RD_LAT=1), rsp0_rdata=0xA5A5; rsp1_valid stays 0.
- req0 and req1 both continuously valid for 8 cycles → exactly 4 grants each, strictly alternating, ready never high for both.
- req1 reads @0x020 with RD_LAT=3 → rsp1_valid exactly 4 edges after acceptance; a back-to-back req0 read @0x021 returns on the next cycle with correct data.
- Assert reset_n=0 one cycle after a read is accepted → no rsp*_valid ever appears for it; all mem_* outputs are 0 after the reset edge.
- Only req1 valid, writes 0x1234 @0x200 → accepted the same cycle; next cycle mem_wr_en=1, mem_rd_en=0, mem_addr=0x200, mem_wr_data=0x1234; no response strobe.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin front end for a single-port synchronous SRAM macro.
// One command per cycle is accepted and issued to the macro on the next cycle;
// read data is routed back to its requester RD_LAT+1 edges after acceptance.

// Response capture for one requester: registers macro data when the tracking
// pipe says the read at the capture stage belongs to this requester.
module mem_port_arbiter_rsp #(
  parameter int   DW = 16,
  parameter logic ID = 1'b0
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          hit_vld,
  input  logic          hit_id,
  input  logic [DW-1:0] rd_data,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata
);

  logic hit;
  assign hit = hit_vld && (hit_id == ID);

  // One-cycle strobe per returning read; data holds until the next one.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= hit;
      if (hit) rsp_rdata <= rd_data;
    end
  end

endmodule

module mem_port_arbiter #(
  parameter int AW     = 10,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_wr,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_wr,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          mem_chip_en,
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_rd_data
);

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  req_t [1:0] req;
  logic [1:0] vld;
  logic [1:0] rdy;
  logic       ptr;       // requester favoured when both are valid
  logic       acc;
  logic       gid;
  req_t       win;

  // Read tracking: stage k holds the command accepted k edges ago.
  logic [RD_LAT:0] vld_pipe;
  logic [RD_LAT:0] id_pipe;

  logic [1:0]          rsp_vld;
  logic [1:0][DW-1:0]  rsp_dat;

  assign req[0] = '{wr: req0_wr, addr: req0_addr, wdata: req0_wdata};
  assign req[1] = '{wr: req1_wr, addr: req1_addr, wdata: req1_wdata};
  assign vld    = {req1_valid, req0_valid};

  // Round-robin grant; nothing is granted while reset is held.
  always_comb begin
    rdy = 2'b00;
    if (reset_n) begin
      unique case (vld)
        2'b01:   rdy = 2'b01;
        2'b10:   rdy = 2'b10;
        2'b11:   rdy = ptr ? 2'b10 : 2'b01;
        default: rdy = 2'b00;
      endcase
    end
  end

  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];
  assign acc        = |rdy;
  assign gid        = rdy[1];
  assign win        = req[gid];

  // Pointer hands priority to the other requester after every acceptance.
  always_ff @(posedge clock) begin
    if (!reset_n)  ptr <= 1'b0;
    else if (acc)  ptr <= ~gid;
  end

  // Macro command register: strobes last one cycle, address/data hold when idle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mem_chip_en <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      mem_chip_en <= acc;
      mem_wr_en   <= acc &&  win.wr;
      mem_rd_en   <= acc && !win.wr;
      if (acc) begin
        mem_addr    <= win.addr;
        mem_wr_data <= win.wdata;
      end
    end
  end

  // Tracking shift register; cleared on reset so in-flight reads are dropped.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RD_LAT-1:0], acc && !win.wr};
      id_pipe  <= {id_pipe[RD_LAT-1:0], gid};
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_rsp
    mem_port_arbiter_rsp #(.DW(DW), .ID(1'(i))) u_rsp (
      .clock     (clock),
      .reset_n   (reset_n),
      .hit_vld   (vld_pipe[RD_LAT]),
      .hit_id    (id_pipe[RD_LAT]),
      .rd_data   (mem_rd_data),
      .rsp_valid (rsp_vld[i]),
      .rsp_rdata (rsp_dat[i])
    );
  end

  assign rsp0_valid = rsp_vld[0];
  assign rsp0_rdata = rsp_dat[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp1_rdata = rsp_dat[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (RD_LAT=1 and RD_LAT=3), each with
// a behavioural SRAM model. Directed stimulus pushes expected macro commands
// and responses into queues; a monitor pops and compares them on every cycle.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk = 0;
  int errs = 0;

  logic          rstn [2];
  logic          rv   [2][2];
  logic          rw   [2][2];
  logic          rr   [2][2];
  logic          sv   [2][2];
  logic [AW-1:0] ra   [2][2];
  logic [DW-1:0] rd   [2][2];
  logic [DW-1:0] srd  [2][2];
  logic          mce  [2];
  logic          mwe  [2];
  logic          mre  [2];
  logic [AW-1:0] ma   [2];
  logic [DW-1:0] mwd  [2];

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            c;
  } cmd_t;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } rsp_t;

  cmd_t cmdq [2][$];
  rsp_t rspq [2][2][$];

  function automatic int lat(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] q   [0:L-1];

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(L)) u_dut (
      .clock       (clk),
      .reset_n     (rstn[g]),
      .req0_valid  (rv[g][0]),
      .req0_ready  (rr[g][0]),
      .req0_wr     (rw[g][0]),
      .req0_addr   (ra[g][0]),
      .req0_wdata  (rd[g][0]),
      .rsp0_valid  (sv[g][0]),
      .rsp0_rdata  (srd[g][0]),
      .req1_valid  (rv[g][1]),
      .req1_ready  (rr[g][1]),
      .req1_wr     (rw[g][1]),
      .req1_addr   (ra[g][1]),
      .req1_wdata  (rd[g][1]),
      .rsp1_valid  (sv[g][1]),
      .rsp1_rdata  (srd[g][1]),
      .mem_chip_en (mce[g]),
      .mem_wr_en   (mwe[g]),
      .mem_rd_en   (mre[g]),
      .mem_addr    (ma[g]),
      .mem_wr_data (mwd[g]),
      .mem_rd_data (q[L-1])
    );

    // SRAM model: samples on the edge, data valid L-1 edges later.
    always @(posedge clk) begin
      if (mce[g] && mwe[g]) mem[ma[g]] <= mwd[g];
      q[0] <= (mce[g] && mre[g]) ? mem[ma[g]] : 'x;
      for (int k = 1; k < L; k++) q[k] <= q[k-1];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of requests; eg is the hand-computed winner (-1 = none).
  task automatic drive(input int g,
                       input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input int eg, input logic exp_rsp, input logic [DW-1:0] erd);
    cmd_t c;
    rsp_t r;
    rv[g][0] = v0; rw[g][0] = w0; ra[g][0] = a0; rd[g][0] = d0;
    rv[g][1] = v1; rw[g][1] = w1; ra[g][1] = a1; rd[g][1] = d1;
    if (eg >= 0) begin
      c.wr   = (eg == 1) ? w1 : w0;
      c.addr = (eg == 1) ? a1 : a0;
      c.wd   = (eg == 1) ? d1 : d0;
      c.c    = cyc + 1;
      cmdq[g].push_back(c);
      if (!c.wr && exp_rsp) begin
        r.d = erd;
        r.c = cyc + 2 + lat(g);
        rspq[g][eg].push_back(r);
      end
    end
    @(negedge clk);
    check("ready0", 32'(rr[g][0]), 32'(eg == 0));
    check("ready1", 32'(rr[g][1]), 32'(eg == 1));
    @(posedge clk); #1;
  endtask

  task automatic idle(input int g, input int n);
    for (int i = 0; i < n; i++) drive(g, 0, 0, '0, '0, 0, 0, '0, '0, -1, 0, '0);
  endtask

  task automatic check_cleared(input int g, input string tag);
    check({tag, "_chip_en"}, 32'(mce[g]), 0);
    check({tag, "_wr_en"},   32'(mwe[g]), 0);
    check({tag, "_rd_en"},   32'(mre[g]), 0);
    check({tag, "_addr"},    32'(ma[g]),  0);
    check({tag, "_wdata"},   32'(mwd[g]), 0);
    check({tag, "_rsp0v"},   32'(sv[g][0]), 0);
    check({tag, "_rsp1v"},   32'(sv[g][1]), 0);
    check({tag, "_rsp0d"},   32'(srd[g][0]), 0);
    check({tag, "_rsp1d"},   32'(srd[g][1]), 0);
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      rstn[g] = 1'b0;
      for (int r = 0; r < 2; r++) begin
        rv[g][r] = 0; rw[g][r] = 0; ra[g][r] = '0; rd[g][r] = '0;
      end
    end
    fork
      begin : monitor
        cmd_t e;
        rsp_t f;
        forever begin
          @(negedge clk);
          for (int g = 0; g < 2; g++) begin
            check("one_ready", 32'(rr[g][0] && rr[g][1]), 0);
            if (mce[g]) begin
              if (cmdq[g].size() == 0) begin
                chk++; errs++;
                $display("FAIL cmd_unexpected inst=%0d actual addr=%0h required none", g, ma[g]);
              end else begin
                e = cmdq[g].pop_front();
                check("cmd_wr_en", 32'(mwe[g]), 32'(e.wr));
                check("cmd_rd_en", 32'(mre[g]), 32'(!e.wr));
                check("cmd_addr",  32'(ma[g]),  32'(e.addr));
                check("cmd_wdata", 32'(mwd[g]), 32'(e.wd));
                check("cmd_cycle", 32'(cyc),    32'(e.c));
              end
            end else begin
              check("idle_ctl", 32'(mwe[g] || mre[g]), 0);
              if (cmdq[g].size() > 0 && cmdq[g][0].c <= cyc) begin
                e = cmdq[g].pop_front();
                chk++; errs++;
                $display("FAIL cmd_missing inst=%0d actual none required addr=%0h", g, e.addr);
              end
            end
            for (int r = 0; r < 2; r++) begin
              if (sv[g][r]) begin
                if (rspq[g][r].size() == 0) begin
                  chk++; errs++;
                  $display("FAIL rsp_unexpected inst=%0d req=%0d actual data=%0h required none", g, r, srd[g][r]);
                end else begin
                  f = rspq[g][r].pop_front();
                  check("rsp_data",  32'(srd[g][r]), 32'(f.d));
                  check("rsp_cycle", 32'(cyc),       32'(f.c));
                end
              end else if (rspq[g][r].size() > 0 && rspq[g][r][0].c <= cyc) begin
                f = rspq[g][r].pop_front();
                chk++; errs++;
                $display("FAIL rsp_missing inst=%0d req=%0d actual none required data=%0h", g, r, f.d);
              end
            end
          end
        end
      end
      begin : stimulus
        int k0, k1, eg;
        // Reset with both requesters valid on instance 0
        rv[0][0] = 1; rw[0][0] = 1; ra[0][0] = 10'h005; rd[0][0] = 16'h1111;
        rv[0][1] = 1; rw[0][1] = 1; ra[0][1] = 10'h3FF; rd[0][1] = 16'h2222;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready0", 32'(rr[0][0]), 0);
        check("rst_ready1", 32'(rr[0][1]), 0);
        check_cleared(0, "rst0");
        check_cleared(1, "rst1");
        @(posedge clk); #1;
        rstn[0] = 1; rstn[1] = 1;
        drive(0, 1, 1, 10'h005, 16'h1111, 1, 1, 10'h3FF, 16'h2222, 0, 0, '0);
        drive(0, 1, 1, 10'h006, 16'h3333, 1, 1, 10'h3FF, 16'h2222, 1, 0, '0);
        drive(0, 1, 1, 10'h006, 16'h3333, 0, 0, '0, '0, 0, 0, '0);
        idle(0, 2);

        // Write then read same address, RD_LAT=1
        drive(0, 1, 1, 10'h010, 16'hA5A5, 0, 0, '0, '0, 0, 0, '0);
        drive(0, 1, 0, 10'h010, 16'h0000, 0, 0, '0, '0, 0, 1, 16'hA5A5);
        idle(0, 3);

        // Both continuously valid: pointer currently favours req1
        k0 = 0; k1 = 0;
        for (int i = 0; i < 8; i++) begin
          eg = (i % 2 == 0) ? 1 : 0;
          drive(0, 1, 1, 10'(10'h100 + k0), 16'(16'hC100 + k0),
                   1, 1, 10'(10'h200 + k1), 16'(16'hD200 + k1), eg, 0, '0);
          if (eg == 1) k1++; else k0++;
        end
        // Cross-requester readbacks
        drive(0, 0, 0, '0, '0, 1, 0, 10'h101, '0, 1, 1, 16'hC101);
        drive(0, 1, 0, 10'h203, '0, 0, 0, '0, '0, 0, 1, 16'hD203);
        idle(0, 3);

        // RD_LAT=3 instance: back-to-back reads from both requesters
        drive(1, 1, 1, 10'h020, 16'hBEEF, 0, 0, '0, '0, 0, 0, '0);
        drive(1, 1, 1, 10'h021, 16'h0F0F, 0, 0, '0, '0, 0, 0, '0);
        drive(1, 0, 0, '0, '0, 1, 0, 10'h020, '0, 1, 1, 16'hBEEF);
        drive(1, 1, 0, 10'h021, '0, 0, 0, '0, '0, 0, 1, 16'h0F0F);
        idle(1, 6);

        // Reset one cycle after a read is accepted: its response is dropped
        drive(0, 1, 0, 10'h010, '0, 0, 0, '0, '0, 0, 0, '0);
        rstn[0] = 0;
        rv[0][0] = 1; rw[0][0] = 1; ra[0][0] = 10'h030; rd[0][0] = 16'h5555;
        rv[0][1] = 1; rw[0][1] = 1; ra[0][1] = 10'h031; rd[0][1] = 16'h6666;
        @(negedge clk);
        check("rst_mid_ready0", 32'(rr[0][0]), 0);
        check("rst_mid_ready1", 32'(rr[0][1]), 0);
        @(posedge clk);
        @(negedge clk);
        check_cleared(0, "rst_mid");
        @(posedge clk); #1;
        rstn[0] = 1;
        drive(0, 1, 1, 10'h030, 16'h5555, 1, 1, 10'h031, 16'h6666, 0, 0, '0);
        drive(0, 0, 0, '0, '0, 1, 1, 10'h031, 16'h6666, 1, 0, '0);
        idle(0, 4);

        // Lone req1 write is accepted the same cycle, no response
        drive(0, 0, 0, '0, '0, 1, 1, 10'h200, 16'h1234, 1, 0, '0);
        drive(0, 1, 0, 10'h200, '0, 0, 0, '0, '0, 0, 1, 16'h1234);
        idle(0, 4);
        idle(1, 1);
      end
    join_any
    for (int g = 0; g < 2; g++) begin
      check("cmdq_drained", 32'(cmdq[g].size()), 0);
      for (int r = 0; r < 2; r++) check("rspq_drained", 32'(rspq[g][r].size()), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", chk, errs);
    $finish;
  end

endmodule
